// File: rtl/mux_arbiter2.sv
// rtl/mux_arbiter2.sv - two-source round-robin packet arbiter driving a 2:1 mux and a registered valid/ready output stage
module mux_arbiter2 #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req1,
    input  logic [DATA_W-1:0] din1,
    input  logic              last1,
    output logic              ack1,
    input  logic              req2,
    input  logic [DATA_W-1:0] din2,
    input  logic              last2,
    output logic              ack2,
    output logic              sel,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_G1   = 2'd1,
        S_G2   = 2'd2
    } state_t;

    // Last counter value before a stalled grant is forcibly released.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state;
    state_t            next_state;

    // Round-robin pointer: 1 when source 2 wins a simultaneous request.
    logic              ptr2;
    logic              ptr2_next;

    // Cycles spent granted with the owner not presenting a beat.
    logic [CNT_W-1:0]  idle_cnt;
    logic [CNT_W-1:0]  idle_cnt_next;

    // sel is held in IDLE, so it is a register rather than a state decode.
    logic              sel_q;
    logic              sel_next;
    logic              terr_next;

    logic              space;
    logic              ack_any;
    logic              granted_g1;
    logic              req_g;
    logic              last_g;
    logic              req_o;
    logic [DATA_W-1:0] mux_data;

    // Output stage can take a new beat when empty or draining this cycle.
    assign space      = ~dout_valid | dout_ready;
    assign granted_g1 = (state == S_G1);

    // Owner/other views of the request lines for the active grant.
    assign req_g      = granted_g1 ? req1  : req2;
    assign last_g     = granted_g1 ? last1 : last2;
    assign req_o      = granted_g1 ? req2  : req1;
    assign ack_any    = ack1 | ack2;

    // The shared mux itself; sel=1 routes din1.
    assign mux_data   = sel_q ? din1 : din2;
    assign sel        = sel_q;

    // State, pointer, counter, select and error-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr2        <= 1'b0;
            idle_cnt    <= '0;
            sel_q       <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            state       <= next_state;
            ptr2        <= ptr2_next;
            idle_cnt    <= idle_cnt_next;
            sel_q       <= sel_next;
            timeout_err <= terr_next;
        end
    end

    // Arbitration, packet lock, end-of-packet hand-over and stall release.
    always_comb begin
        next_state    = state;
        ptr2_next     = ptr2;
        idle_cnt_next = idle_cnt;
        sel_next      = sel_q;
        terr_next     = 1'b0;
        case (state)
            S_IDLE: begin
                idle_cnt_next = '0;
                if (req1 && (!req2 || !ptr2)) begin
                    next_state = S_G1;
                    sel_next   = 1'b1;
                end else if (req2) begin
                    next_state = S_G2;
                    sel_next   = 1'b0;
                end
            end
            S_G1, S_G2: begin
                if (ack_any) begin
                    idle_cnt_next = '0;
                    if (last_g) begin
                        // Hand priority to the other source after every packet.
                        ptr2_next = granted_g1;
                        if (req_o) begin
                            next_state = granted_g1 ? S_G2 : S_G1;
                            sel_next   = ~granted_g1;
                        end else begin
                            next_state = S_IDLE;
                        end
                    end
                end else if (!req_g) begin
                    // Only an absent owner counts; back-pressure stalls do not.
                    if (idle_cnt == CNT_LAST) begin
                        next_state    = S_IDLE;
                        ptr2_next     = granted_g1;
                        idle_cnt_next = '0;
                        terr_next     = 1'b1;
                    end else begin
                        idle_cnt_next = idle_cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                next_state    = S_IDLE;
                idle_cnt_next = '0;
            end
        endcase
    end

    // Per-state outputs: acknowledge only the owner, and only with space.
    always_comb begin
        ack1 = 1'b0;
        ack2 = 1'b0;
        busy = 1'b0;
        case (state)
            S_G1: begin
                ack1 = req1 & space;
                busy = 1'b1;
            end
            S_G2: begin
                ack2 = req2 & space;
                busy = 1'b1;
            end
            default: begin
                ack1 = 1'b0;
                ack2 = 1'b0;
                busy = 1'b0;
            end
        endcase
    end

    // Registered output stage: load on ack, drop valid once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (ack_any) begin
            dout       <= mux_data;
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule
